// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU op codes,
// FSM state encodings, datapath select values and the strobe bundle.
package mips_ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] FUNC_JR  = 6'h08;

  // Shared with the ALU control decoder; do not renumber.
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'h0;
  localparam logic [ALU_OP_W-1:0] ALU_ORI   = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_LUI   = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_ANDI  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_LW    = 4'h4;
  localparam logic [ALU_OP_W-1:0] ALU_SW    = 4'h5;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ   = 4'h6;
  localparam logic [ALU_OP_W-1:0] ALU_BNE   = 4'h7;
  localparam logic [ALU_OP_W-1:0] ALU_J     = 4'h8;
  localparam logic [ALU_OP_W-1:0] ALU_JAL   = 4'h9;
  localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JAL       = 4'd12,
    S_JR        = 4'd13
  } state_e;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_opcode;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_alu_op_encoder.sv
// Maps the current FSM state and the latched opcode to the ALU op code
// consumed by the ALU control decoder.
module alu_op_encoder
  import mips_ctrl_pkg::*;
(
  input  state_e              state,
  input  logic [OP_W-1:0]     opcode,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (state)
      S_MEM_ADDR: alu_op = (opcode == OP_LW) ? ALU_LW : ALU_SW;
      S_R_EXEC:   alu_op = ALU_RTYPE;
      S_I_EXEC: begin
        case (opcode)
          OP_ANDI: alu_op = ALU_ANDI;
          OP_ORI:  alu_op = ALU_ORI;
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_BRANCH:   alu_op = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
      S_JUMP:     alu_op = ALU_J;
      S_JAL:      alu_op = ALU_JAL;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe and mux select.
module multi_cycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode_i,
  input  logic [OP_W-1:0]     function_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_source_o,
  output logic                ir_write_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                illegal_opcode_o,
  output logic [STATE_W-1:0]  state_o
);

  state_e              state;
  state_e              state_next;
  logic [OP_W-1:0]     op_q;
  logic [ALU_OP_W-1:0] alu_op;
  ctrl_t               ctrl;
  ctrl_t               ctrl_out;

  // Opcode is captured in DECODE so later states never look at the live IR bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= opcode_i;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        if (mem_ready_i) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH;
        case (opcode_i)
          OP_RTYPE:                       state_next = (function_i == FUNC_JR) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:                   state_next = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
          OP_BEQ, OP_BNE:                 state_next = S_BRANCH;
          OP_J:                           state_next = S_JUMP;
          OP_JAL:                         state_next = S_JAL;
          default: begin
            ctrl.illegal_opcode = 1'b1;
            state_next          = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready_i) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        state_next      = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        state_next     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
        state_next      = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        state_next     = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
        state_next      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.pc_source = PC_SRC_ALUOUT;
        ctrl.pc_write  = (op_q == OP_BEQ) ? zero_i : ~zero_i;
        state_next     = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
        state_next     = S_FETCH;
      end
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.pc_write   = 1'b1;
        state_next      = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_source = PC_SRC_REG;
        ctrl.pc_write  = 1'b1;
        state_next     = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  alu_op_encoder u_alu_op_encoder (
    .state  (state),
    .opcode (op_q),
    .alu_op (alu_op)
  );

  // Holding reset low silences every strobe immediately, aborting any access in flight.
  assign ctrl_out = reset ? ctrl : '0;

  assign alu_op_o         = reset ? alu_op : '0;
  assign alu_src_a_o      = ctrl_out.alu_src_a;
  assign alu_src_b_o      = ctrl_out.alu_src_b;
  assign pc_write_o       = ctrl_out.pc_write;
  assign pc_source_o      = ctrl_out.pc_source;
  assign ir_write_o       = ctrl_out.ir_write;
  assign iord_o           = ctrl_out.iord;
  assign mem_read_o       = ctrl_out.mem_read;
  assign mem_write_o      = ctrl_out.mem_write;
  assign reg_write_o      = ctrl_out.reg_write;
  assign reg_dst_o        = ctrl_out.reg_dst;
  assign mem_to_reg_o     = ctrl_out.mem_to_reg;
  assign illegal_opcode_o = ctrl_out.illegal_opcode;
  assign state_o          = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized self-checking bench for multi_cycle_control: each instruction is
// expanded into its expected per-cycle control trace and compared cycle by cycle.
module tb_multi_cycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i, function_i;
  logic       zero_i, mem_ready_i;
  logic [3:0] alu_op_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic       pc_write_o;
  logic [1:0] pc_source_o;
  logic       ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0] reg_dst_o, mem_to_reg_o;
  logic       illegal_opcode_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk              (clk),
    .reset            (reset),
    .opcode_i         (opcode_i),
    .function_i       (function_i),
    .zero_i           (zero_i),
    .mem_ready_i      (mem_ready_i),
    .alu_op_o         (alu_op_o),
    .alu_src_a_o      (alu_src_a_o),
    .alu_src_b_o      (alu_src_b_o),
    .pc_write_o       (pc_write_o),
    .pc_source_o      (pc_source_o),
    .ir_write_o       (ir_write_o),
    .iord_o           (iord_o),
    .mem_read_o       (mem_read_o),
    .mem_write_o      (mem_write_o),
    .reg_write_o      (reg_write_o),
    .reg_dst_o        (reg_dst_o),
    .mem_to_reg_o     (mem_to_reg_o),
    .illegal_opcode_o (illegal_opcode_o),
    .state_o          (state_o)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       pw;
    logic [1:0] ps;
    logic       irw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       ill;
  } exp_t;

  typedef struct {
    string tag;
    logic  rdy;
    logic  z;
    logic  ir_valid;
    exp_t  e;
  } cyc_t;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.st = state_o; o.aop = alu_op_o; o.sa = alu_src_a_o; o.sb = alu_src_b_o;
    o.pw = pc_write_o; o.ps = pc_source_o; o.irw = ir_write_o; o.iord = iord_o;
    o.mr = mem_read_o; o.mw = mem_write_o; o.rw = reg_write_o; o.rd = reg_dst_o;
    o.m2r = mem_to_reg_o; o.ill = illegal_opcode_o;
    return o;
  endfunction

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t fetch_e(input logic done);
    exp_t e = '0;
    e.st = S_FETCH; e.mr = 1'b1; e.sb = 2'b01; e.irw = done; e.pw = done;
    return e;
  endfunction

  function automatic void push(input string tag, input logic rdy, input logic z,
                               input logic ir_valid, input exp_t e);
    cyc_t c;
    c.tag = tag; c.rdy = rdy; c.z = z; c.ir_valid = ir_valid; c.e = e;
    q.push_back(c);
  endfunction

  // Expected cycle trace for one instruction, with fw fetch waits and mw memory waits.
  task automatic build(input logic [5:0] op, input logic [5:0] func, input logic z,
                       input int fw, input int mw);
    exp_t e;
    q.delete();
    for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, 1'($urandom), 1'b1, fetch_e(1'b0));
    push("fetch", 1'b1, 1'($urandom), 1'b1, fetch_e(1'b1));
    e = '0; e.st = S_DECODE; e.sb = 2'b11; e.ill = ~legal(op);
    push("decode", 1'($urandom), 1'($urandom), 1'b1, e);
    if (op == 6'h23 || op == 6'h2B) begin
      e = '0; e.st = S_MEM_ADDR; e.sa = 1'b1; e.sb = 2'b10; e.aop = (op == 6'h23) ? 4'h4 : 4'h5;
      push("mem_addr", 1'($urandom), 1'($urandom), 1'b0, e);
      e = '0; e.iord = 1'b1;
      if (op == 6'h23) begin e.st = S_MEM_READ; e.mr = 1'b1; end
      else begin e.st = S_MEM_WRITE; e.mw = 1'b1; end
      for (int i = 0; i < mw; i++) push("mem_wait", 1'b0, 1'($urandom), 1'b0, e);
      push("mem_done", 1'b1, 1'($urandom), 1'b0, e);
      if (op == 6'h23) begin
        e = '0; e.st = S_MEM_WB; e.rw = 1'b1; e.m2r = 2'b01;
        push("mem_wb", 1'($urandom), 1'($urandom), 1'b0, e);
      end
    end else if (op == 6'h00 && func == 6'h08) begin
      e = '0; e.st = S_JR; e.ps = 2'b11; e.pw = 1'b1;
      push("jr", 1'($urandom), 1'($urandom), 1'b0, e);
    end else if (op == 6'h00) begin
      e = '0; e.st = S_R_EXEC; e.sa = 1'b1; e.aop = 4'hF;
      push("r_exec", 1'($urandom), 1'($urandom), 1'b0, e);
      e = '0; e.st = S_R_WB; e.rw = 1'b1; e.rd = 2'b01;
      push("r_wb", 1'($urandom), 1'($urandom), 1'b0, e);
    end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
      e = '0; e.st = S_I_EXEC; e.sa = 1'b1; e.sb = 2'b10;
      e.aop = (op == 6'h0C) ? 4'h3 : (op == 6'h0D) ? 4'h1 : (op == 6'h0F) ? 4'h2 : 4'h0;
      push("i_exec", 1'($urandom), 1'($urandom), 1'b0, e);
      e = '0; e.st = S_I_WB; e.rw = 1'b1;
      push("i_wb", 1'($urandom), 1'($urandom), 1'b0, e);
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0; e.st = S_BRANCH; e.sa = 1'b1; e.ps = 2'b01;
      e.aop = (op == 6'h04) ? 4'h6 : 4'h7;
      e.pw  = (op == 6'h04) ? z : ~z;
      push("branch", 1'($urandom), z, 1'b0, e);
    end else if (op == 6'h02) begin
      e = '0; e.st = S_JUMP; e.aop = 4'h8; e.ps = 2'b10; e.pw = 1'b1;
      push("jump", 1'($urandom), 1'($urandom), 1'b0, e);
    end else if (op == 6'h03) begin
      e = '0; e.st = S_JAL; e.aop = 4'h9; e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10;
      e.ps = 2'b10; e.pw = 1'b1;
      push("jal", 1'($urandom), 1'($urandom), 1'b0, e);
    end
  endtask

  // Replays the trace; opcode/function are scrambled once the IR may be ignored.
  task automatic run(input logic [5:0] op, input logic [5:0] func, input int ncyc);
    for (int i = 0; i < q.size(); i++) begin
      if (ncyc >= 0 && i >= ncyc) break;
      @(negedge clk);
      mem_ready_i = q[i].rdy;
      zero_i      = q[i].z;
      opcode_i    = q[i].ir_valid ? op   : 6'($urandom);
      function_i  = q[i].ir_valid ? func : 6'($urandom);
      #1;
      check_eq(q[i].tag, 32'(observed()), 32'(q[i].e));
    end
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] func, input logic z,
                          input int fw, input int mw);
    build(op, func, z, fw, mw);
    run(op, func, -1);
  endtask

  task automatic check_reset_quiet(input string tag);
    exp_t o;
    o = observed();
    check_eq(tag, 32'(o[19:0]), 32'h0);
  endtask

  initial begin
    logic [5:0] ops [12];
    logic [5:0] op, func;
    int         sel;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};

    reset = 1'b0; opcode_i = 6'($urandom); function_i = 6'($urandom);
    zero_i = 1'b1; mem_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      opcode_i = 6'($urandom); function_i = 6'($urandom);
      zero_i = 1'($urandom); mem_ready_i = 1'($urandom);
      #1;
      check_reset_quiet("reset_quiet");
    end
    @(negedge clk);
    reset = 1'b1; mem_ready_i = 1'b0;
    #1;
    check_eq("reset_release", 32'(observed()), 32'(fetch_e(1'b0)));

    do_instr(6'h00, 6'h20, 1'b0, 0, 0);
    do_instr(6'h23, 6'h15, 1'b0, 0, 3);
    do_instr(6'h04, 6'h00, 1'b1, 1, 0);
    do_instr(6'h05, 6'h00, 1'b1, 0, 0);
    do_instr(6'h05, 6'h00, 1'b0, 0, 0);
    do_instr(6'h03, 6'h00, 1'b0, 0, 0);
    do_instr(6'h00, 6'h08, 1'b0, 0, 0);
    do_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    do_instr(6'h0F, 6'h00, 1'b0, 2, 0);
    do_instr(6'h2B, 6'h00, 1'b0, 0, 2);

    // Store held waiting in MEM_WRITE, then aborted by reset.
    build(6'h2B, 6'h00, 1'b0, 0, 5);
    run(6'h2B, 6'h00, 4);
    @(negedge clk);
    reset = 1'b0; mem_ready_i = 1'b1;
    #1;
    check_reset_quiet("abort_mem_write");
    @(negedge clk);
    reset = 1'b1; mem_ready_i = 1'b0;
    #1;
    check_eq("abort_release", 32'(observed()), 32'(fetch_e(1'b0)));

    for (int n = 0; n < 120; n++) begin
      sel  = $urandom_range(0, 12);
      func = 6'($urandom);
      if (sel == 12) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end else begin
        op = ops[sel];
        if (sel == 0 && func == 6'h08) func = 6'h20;
        if (sel == 1) func = 6'h08;
      end
      do_instr(op, func, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
